// File: rtl/camera_downsampler.sv
// OV7670 RGB565 byte-stream capture: assembles RGB332 pixels and issues frame-buffer
// write strobes clipped to a WIDTH x HEIGHT window, flagging odd-byte lines.
module camera_downsampler #(
  parameter int unsigned WIDTH      = 176,
  parameter int unsigned HEIGHT     = 144,
  parameter bit          SWAP_BYTES = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] DATA,
  output logic [7:0] PIXEL_OUT,
  output logic [9:0] X_ADDR,
  output logic [9:0] Y_ADDR,
  output logic       W_EN,
  output logic       FRAME_DONE,
  output logic       SYNC_ERR
);

  localparam logic [9:0] WidthLim  = 10'(WIDTH);
  localparam logic [9:0] HeightLim = 10'(HEIGHT);
  localparam logic [9:0] CountMax  = 10'd1023;

  typedef enum logic [1:0] {StSync, StVblank, StLine, StLo} state_e;

  state_e      state_q, state_d;
  logic        vsync_q, href_q;
  logic [7:0]  first_q, first_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        wrote_q, wrote_d;
  logic [7:0]  pixel_q, pixel_d;
  logic [9:0]  x_addr_q, x_addr_d, y_addr_q, y_addr_d;
  logic        w_en_q, w_en_d;
  logic        frame_done_q, frame_done_d;
  logic        sync_err_q, sync_err_d;

  logic        vs_rise, vs_fall, hr_fall, in_window;
  logic [7:0]  hi_byte, lo_byte, pixel_new;

  assign vs_rise   = VSYNC & ~vsync_q;
  assign vs_fall   = ~VSYNC & vsync_q;
  assign hr_fall   = ~HREF & href_q;
  assign in_window = (x_q < WidthLim) && (y_q < HeightLim);

  // hi carries {R[4:0],G[5:3]}, lo carries {G[2:0],B[4:0]}.
  assign hi_byte   = SWAP_BYTES ? DATA : first_q;
  assign lo_byte   = SWAP_BYTES ? first_q : DATA;
  assign pixel_new = {hi_byte[7:5], hi_byte[2:0], lo_byte[4:3]};

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    x_d          = x_q;
    y_d          = y_q;
    wrote_d      = wrote_q;
    pixel_d      = pixel_q;
    x_addr_d     = x_addr_q;
    y_addr_d     = y_addr_q;
    w_en_d       = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;

    if (state_q == StSync) begin
      // Wait for a blanking interval so the partial first frame is discarded.
      if (VSYNC) state_d = StVblank;
    end else if (vs_rise) begin
      // Takes priority over any line activity; a partial pixel is simply abandoned.
      state_d      = StVblank;
      frame_done_d = wrote_q;
      wrote_d      = 1'b0;
    end else begin
      unique case (state_q)
        StVblank: begin
          if (vs_fall) begin
            state_d = StLine;
            x_d     = '0;
            y_d     = '0;
            wrote_d = 1'b0;
          end
        end
        StLine, StLo: begin
          if (hr_fall) begin
            x_d     = '0;
            y_d     = (y_q == CountMax) ? y_q : y_q + 10'd1;
            state_d = StLine;
            if (state_q == StLo) sync_err_d = 1'b1;
          end else if (HREF) begin
            if (state_q == StLine) begin
              first_d = DATA;
              state_d = StLo;
            end else begin
              pixel_d  = pixel_new;
              x_addr_d = x_q;
              y_addr_d = y_q;
              w_en_d   = in_window;
              wrote_d  = wrote_q | in_window;
              x_d      = (x_q == CountMax) ? x_q : x_q + 10'd1;
              state_d  = StLine;
            end
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StSync;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      first_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wrote_q      <= 1'b0;
      pixel_q      <= '0;
      x_addr_q     <= '0;
      y_addr_q     <= '0;
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= VSYNC;
      href_q       <= HREF;
      first_q      <= first_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wrote_q      <= wrote_d;
      pixel_q      <= pixel_d;
      x_addr_q     <= x_addr_d;
      y_addr_q     <= y_addr_d;
      w_en_q       <= w_en_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign PIXEL_OUT  = pixel_q;
  assign X_ADDR     = x_addr_q;
  assign Y_ADDR     = y_addr_q;
  assign W_EN       = w_en_q;
  assign FRAME_DONE = frame_done_q;
  assign SYNC_ERR   = sync_err_q;

endmodule

// File: tb/tb_camera_downsampler.sv
// Bench for camera_downsampler: transaction-level model of expected writes and frame ends,
// checked every cycle against a plain and a byte-swapped instance.
`timescale 1ns/1ps
module tb_camera_downsampler;

  localparam int W = 176;
  localparam int H = 144;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] data = 8'h00;

  logic [7:0] pix0, pix1;
  logic [9:0] x0, y0, x1, y1;
  logic       we0, we1, fd0, fd1, se0, se1;

  always #5 clk = ~clk;

  camera_downsampler #(.WIDTH(W), .HEIGHT(H), .SWAP_BYTES(1'b0)) dut (
    .CLK(clk), .RESET_N(rst_n), .VSYNC(vsync), .HREF(href), .DATA(data),
    .PIXEL_OUT(pix0), .X_ADDR(x0), .Y_ADDR(y0), .W_EN(we0), .FRAME_DONE(fd0), .SYNC_ERR(se0)
  );

  camera_downsampler #(.WIDTH(W), .HEIGHT(H), .SWAP_BYTES(1'b1)) dut_sw (
    .CLK(clk), .RESET_N(rst_n), .VSYNC(vsync), .HREF(href), .DATA(data),
    .PIXEL_OUT(pix1), .X_ADDR(x1), .Y_ADDR(y1), .W_EN(we1), .FRAME_DONE(fd1), .SYNC_ERR(se1)
  );

  typedef struct {
    int         x;
    int         y;
    logic [7:0] p0;
    logic [7:0] p1;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got_q[$];
  wr_t        mon_e;
  logic [7:0] line_bytes[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_done = 0;
  int         got_done = 0;
  int         got_done_sw = 0;
  int         line_y = 0;
  bit         exp_err = 1'b0;
  bit         in_frame = 1'b0;
  bit         frame_wrote = 1'b0;
  bit         mon_en = 1'b0;

  function automatic logic [7:0] to_rgb332(input logic [15:0] rgb565);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = rgb565[15:11];
    g = rgb565[10:5];
    b = rgb565[4:0];
    return {r[4:2], g[5:3], b[4:3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, got, got, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    line_bytes.delete();
    for (int i = 0; i < n; i++) line_bytes.push_back(8'($urandom));
  endtask

  task automatic fill_pixels(input int npx, input logic [15:0] px);
    line_bytes.delete();
    for (int i = 0; i < npx; i++) begin
      line_bytes.push_back(px[15:8]);
      line_bytes.push_back(px[7:0]);
    end
  endtask

  // Drives the first n queued bytes with HREF high, recording every complete in-window pixel.
  task automatic drive_bytes(input int n);
    logic [7:0] b0, b1;
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      data = line_bytes[i];
      if ((i % 2 == 1) && in_frame && (i / 2 < W) && (line_y < H)) begin
        b0 = line_bytes[i-1];
        b1 = line_bytes[i];
        exp_q.push_back('{x: i / 2, y: line_y, p0: to_rgb332({b0, b1}), p1: to_rgb332({b1, b0})});
        frame_wrote = 1'b1;
      end
      tick();
    end
  endtask

  task automatic send_line(input int gap);
    int n;
    n = line_bytes.size();
    drive_bytes(n);
    href = 1'b0;
    data = 8'h00;
    tick();
    if (n > 0 && in_frame) begin
      if (n % 2 == 1) exp_err = 1'b1;
      line_y++;
    end
    repeat (gap - 1) tick();
  endtask

  task automatic vsync_pulse(input int hi);
    vsync = 1'b1;
    tick();
    href = 1'b0;
    data = 8'h00;
    if (in_frame && frame_wrote) exp_done++;
    frame_wrote = 1'b0;
    repeat (hi - 1) tick();
    vsync = 1'b0;
    tick();
    in_frame = 1'b1;
    line_y = 0;
    repeat (2) tick();
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_frame_done"}, got_done, exp_done);
    chk({tag, "_frame_done_swap"}, got_done_sw, exp_done);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("sync_err", se0, exp_err);
      chk("sync_err_swap", se1, exp_err);
      if (fd0) got_done++;
      if (fd1) got_done_sw++;
      if (we0 || we1) begin
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("w_en", we0, 1);
          chk("w_en_swap", we1, 1);
          chk("x_addr", x0, mon_e.x);
          chk("y_addr", y0, mon_e.y);
          chk("pixel", pix0, mon_e.p0);
          chk("x_addr_swap", x1, mon_e.x);
          chk("y_addr_swap", y1, mon_e.y);
          chk("pixel_swap", pix1, mon_e.p1);
          chk("x_in_window", int'(x0 < 10'(W)), 1);
          chk("y_in_window", int'(y0 < 10'(H)), 1);
          got_q.push_back('{x: int'(x0), y: int'(y0), p0: pix0, p1: pix1});
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base;
    int gw;
    int nlines;
    int n;
    int mx;
    int my;

    repeat (3) tick();
    chk("reset_w_en", we0, 0);
    chk("reset_frame_done", fd0, 0);
    chk("reset_sync_err", se0, 0);
    chk("reset_pixel", pix0, 0);
    chk("reset_x", x0, 0);
    chk("reset_y", y0, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Two-pixel line after the first blanking interval.
    vsync_pulse(3);
    got_q.delete();
    line_bytes.delete();
    line_bytes.push_back(8'hF8);
    line_bytes.push_back(8'h00);
    line_bytes.push_back(8'h07);
    line_bytes.push_back(8'hE0);
    send_line(2);
    chk("t1_writes", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("t1_x0", got_q[0].x, 0);
      chk("t1_y0", got_q[0].y, 0);
      chk("t1_pix0", got_q[0].p0, 8'hE0);
      chk("t1_x1", got_q[1].x, 1);
      chk("t1_y1", got_q[1].y, 0);
      chk("t1_pix1", got_q[1].p0, 8'h1C);
    end

    // Frame end pulses once; an empty frame does not.
    base = got_done;
    vsync_pulse(3);
    chk("t1_frame_done", got_done - base, 1);
    base = got_done;
    gw = got_q.size();
    vsync_pulse(4);
    repeat (5) tick();
    chk("t6_no_frame_done", got_done - base, 0);
    chk("t6_no_write", got_q.size() - gw, 0);
    got_q.delete();
    line_bytes.delete();
    line_bytes.push_back(8'h00);
    line_bytes.push_back(8'hF8);
    send_line(2);
    chk("t6_writes", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("t6_swap_pix", got_q[0].p1, 8'hE0);
      chk("t6_plain_pix", got_q[0].p0, 8'h03);
    end

    // VSYNC rising mid-pixel abandons the line without a sync error.
    fill_rand(6);
    drive_bytes(5);
    data = line_bytes[5];
    vsync_pulse(3);
    chk("abandon_no_sync_err", se0, 0);

    // Full frame of blue pixels.
    base = got_done;
    got_q.delete();
    for (int l = 0; l < H; l++) begin
      fill_pixels(W, 16'h001F);
      send_line(2);
    end
    vsync_pulse(3);
    chk("t2_writes", got_q.size(), W * H);
    if (got_q.size() > 0) begin
      chk("t2_last_x", got_q[got_q.size()-1].x, 175);
      chk("t2_last_y", got_q[got_q.size()-1].y, 143);
      chk("t2_last_pix", got_q[got_q.size()-1].p0, 8'h03);
    end
    chk("t2_frame_done", got_done - base, 1);

    // Oversized frame: wide lines at top and around the bottom edge, 150 lines total.
    got_q.delete();
    for (int l = 0; l < 150; l++) begin
      fill_pixels((l < 3 || l >= 143) ? 200 : 2, 16'(l * 977));
      send_line(2);
    end
    vsync_pulse(3);
    chk("t3_writes", got_q.size(), 3 * 176 + 140 * 2 + 176);
    mx = 0;
    my = 0;
    foreach (got_q[i]) begin
      if (got_q[i].x > mx) mx = got_q[i].x;
      if (got_q[i].y > my) my = got_q[i].y;
    end
    chk("t3_max_x", mx, 175);
    chk("t3_max_y", my, 143);

    // Odd-byte line, then a normal line.
    got_q.delete();
    fill_rand(7);
    send_line(2);
    chk("t4_sync_err", se0, 1);
    fill_rand(4);
    send_line(2);
    chk("t4_writes", got_q.size(), 5);
    if (got_q.size() >= 5) begin
      chk("t4_third_x", got_q[2].x, 2);
      chk("t4_next_x", got_q[3].x, 0);
      chk("t4_next_y", got_q[3].y, 1);
    end
    vsync_pulse(3);

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      nlines = $urandom_range(1, 8);
      for (int l = 0; l < nlines; l++) begin
        if (l == nlines - 1 && $urandom_range(0, 3) == 0) begin
          n = $urandom_range(1, 20);
          fill_rand(n + 1);
          drive_bytes(n);
          data = line_bytes[n];
        end else begin
          fill_rand($urandom_range(1, 40));
          send_line($urandom_range(1, 4));
        end
      end
      vsync_pulse($urandom_range(2, 5));
    end
    repeat (3) tick();
    chk_counts("random");

    // Asynchronous reset mid-line.
    href = 1'b1;
    data = 8'($urandom);
    tick();
    data = 8'($urandom);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    in_frame = 1'b0;
    frame_wrote = 1'b0;
    href = 1'b0;
    data = 8'h00;
    #2;
    chk("t5_w_en", we0, 0);
    chk("t5_w_en_swap", we1, 0);
    chk("t5_sync_err", se0, 0);
    chk("t5_frame_done", fd0, 0);
    chk("t5_pixel", pix0, 0);
    chk("t5_x", x0, 0);
    chk("t5_y", y0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    got_q.delete();
    fill_rand(8);
    send_line(2);
    chk("t5_ignored_before_vsync", got_q.size(), 0);
    vsync_pulse(3);
    line_bytes.delete();
    line_bytes.push_back(8'hF8);
    line_bytes.push_back(8'h00);
    send_line(2);
    chk("t5_resume_writes", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("t5_resume_x", got_q[0].x, 0);
      chk("t5_resume_y", got_q[0].y, 0);
      chk("t5_resume_pix", got_q[0].p0, 8'hE0);
    end

    vsync_pulse(3);
    repeat (4) tick();
    chk_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
